fetch_queue_unit: RTL

- Parametrised successor to the fixed single-register fetch stage of the 5-stage RV32I core.
- Decouples PC generation and instruction-memory access from decode through a DEPTH-entry in-order instruction queue.
- Supports multiple outstanding imem requests with variable response latency and BTB-directed next-PC selection.
- Execute-stage redirects squash queued and in-flight fetches.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_ring.sv | 59 +++++
 rtl/fetch_queue_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch queue: one queue entry carries a fetched
// instruction plus the PC context decode needs.
package fetch_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] pcPlus4;
    logic [31:0]             instr;
    logic                    predTaken;
    logic                    filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_ring.sv
// Circular entry store with head (pop), tail (alloc) and fill (oldest unfilled) pointers.
// Single-cycle registered updates; the caller guarantees alloc only when not full and fill only when unfilled>0.
module fetch_ring
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       alloc,
  input  logic [XLEN_DEFAULT-1:0]    allocPc,
  input  logic [XLEN_DEFAULT-1:0]    allocPcPlus4,
  input  logic                       allocPredTaken,
  input  logic                       fill,
  input  logic [31:0]                fillData,
  input  logic                       pop,
  output fetch_entry_t               headEntry,
  output logic [$clog2(QDEPTH):0]    count,
  output logic [$clog2(QDEPTH):0]    unfilled
);

  localparam int AW = $clog2(QDEPTH);

  fetch_entry_t     entries [QDEPTH];
  logic [AW:0]      headPtr;
  logic [AW:0]      tailPtr;
  logic [AW:0]      fillPtr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count     = tailPtr - headPtr;
  assign unfilled  = tailPtr - fillPtr;
  assign headEntry = entries[headPtr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      headPtr <= '0;
      tailPtr <= '0;
      fillPtr <= '0;
      for (int i = 0; i < QDEPTH; i++) entries[i] <= '0;
    end else begin
      if (alloc) begin
        entries[tailPtr[AW-1:0]] <= '{pc: allocPc, pcPlus4: allocPcPlus4, instr: NOP_INSTR,
                                       predTaken: allocPredTaken, filled: 1'b0};
        tailPtr <= tailPtr + 1'b1;
      end
      if (fill) begin
        entries[fillPtr[AW-1:0]].instr  <= fillData;
        entries[fillPtr[AW-1:0]].filled <= 1'b1;
        fillPtr <= fillPtr + 1'b1;
      end
      if (pop) begin
        entries[headPtr[AW-1:0]].filled <= 1'b0;
        headPtr <= headPtr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// In-order fetch queue with BTB-steered PC, multiple outstanding imem requests and redirect squash.
// Response in cycle N is visible to decode in N+1; issue stalls at full, decode stalls via decReady. Optional FETCH_PERF_CNT_EN adds perf counters.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              QDEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imemReqValid,
  input  logic                       imemReqReady,
  output logic [XLEN-1:0]            imemAddr,
  input  logic                       imemRspValid,
  input  logic [31:0]                imemRspData,
  input  logic                       predHit,
  input  logic [XLEN-1:0]            predTarget,
  input  logic                       redirectValid,
  input  logic [XLEN-1:0]            redirectPc,
  output logic                       decValid,
  input  logic                       decReady,
  output logic [31:0]                decInstr,
  output logic [XLEN-1:0]            decPc,
  output logic [XLEN-1:0]            decPcPlus4,
  output logic                       decPredTaken,
`ifdef FETCH_PERF_CNT_EN
  output logic [$clog2(QDEPTH):0]    occupancy,
  output logic [31:0]                perfStallCycles,
  output logic [31:0]                perfDropCount
`else
  output logic [$clog2(QDEPTH):0]    occupancy
`endif
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pcPlus4;
  logic [CW-1:0]   dropCnt;
  logic [CW-1:0]   count;
  logic [CW-1:0]   unfilled;
  fetch_entry_t    headEntry;
  logic            headValid;
  logic            reqFire;
  logic            rspDrop;
  logic            rspFill;
  logic            popFire;

  assign pcPlus4      = pc + XLEN'(4);
  assign imemReqValid = !rst && !redirectValid && (count < CW'(QDEPTH));
  assign reqFire      = imemReqValid && imemReqReady;
  assign rspDrop      = imemRspValid && (dropCnt != '0);
  assign rspFill      = imemRspValid && (dropCnt == '0) && (unfilled != '0);
  assign headValid    = headEntry.filled && (count != '0);
  assign decValid     = !rst && headValid && !redirectValid;
  assign popFire      = decValid && decReady;

  assign imemAddr     = rst ? '0 : pc;
  assign occupancy    = rst ? '0 : count;
  assign decInstr     = rst ? '0 : headEntry.instr;
  assign decPc        = rst ? '0 : XLEN'(headEntry.pc);
  assign decPcPlus4   = rst ? '0 : XLEN'(headEntry.pcPlus4);
  assign decPredTaken = rst ? 1'b0 : headEntry.predTaken;

  fetch_ring #(.QDEPTH(QDEPTH)) ring (
    .clk            (clk),
    .rst            (rst),
    .clear          (redirectValid),
    .alloc          (reqFire),
    .allocPc        (XLEN_DEFAULT'(pc)),
    .allocPcPlus4   (XLEN_DEFAULT'(pcPlus4)),
    .allocPredTaken (predHit),
    .fill           (rspFill),
    .fillData       (imemRspData),
    .pop            (popFire),
    .headEntry      (headEntry),
    .count          (count),
    .unfilled       (unfilled)
  );

  // On redirect every unfilled allocation becomes a response to throw away.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      dropCnt <= '0;
    end else if (redirectValid) begin
      pc      <= redirectPc;
      dropCnt <= dropCnt + unfilled - CW'(rspDrop || rspFill);
    end else begin
      if (reqFire) pc <= predHit ? predTarget : pcPlus4;
      if (rspDrop) dropCnt <= dropCnt - 1'b1;
    end
  end

  assert property (@(posedge clk) disable iff (rst)
    !(imemRspValid && (dropCnt == '0) && (unfilled == '0)));

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perfStallCycles <= '0;
      perfDropCount   <= '0;
    end else begin
      if ((count == CW'(QDEPTH)) && !decValid && (perfStallCycles != '1))
        perfStallCycles <= perfStallCycles + 1'b1;
      if (rspDrop && (perfDropCount != '1))
        perfDropCount <= perfDropCount + 1'b1;
    end
  end
`endif

endmodule
